fp_sqrt_rnd: RTL and testbench
==============================

// Module: fp_sqrt_rnd
// PURPOSE
//  Iterative IEEE-754 binary32 square root with integrated rounding and exception flags.
//  - Takes one operand and a rounding mode.
//  - Returns the correctly rounded root plus a 5-bit status word after a fixed latency.
//  - Sits in the FPU beside the divider; it is the sqrt path of the FP execution unit.
// PARAMETERS
//  EXP_W  8   exponent width (only 8 supported)
//  MAN_W  23  stored mantissa width (only 23 supported)
// PORTS
//  clk_i     in   1   single clock, rising edge
//  reset_i   in   1   asynchronous, active-low reset
//  a_i       in   32  operand {sign, exp[7:0], man[22:0]}
//  start_i   in   1   start pulse; sampled only in IDLE
//  rnd_i     in   3   rounding mode: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4; others treated as RNE
//  done_o    out  1   one-cycle pulse: result_o/flags_o valid
//  result_o  out  32  rounded result, held until next accepted start
//  flags_o   out  5   {NV,DZ,OF,UF,NX}, held with result_o
// BEHAVIOUR
//  - Reset (reset_i=0): state IDLE; done_o=0, result_o=0, flags_o=0. Asserting reset mid-operation aborts; no done_o.
//  - FSM IDLE -> PREP -> ITER -> RND -> IDLE.
//  - Latency: done_o rises exactly MAN_W+4 = 27 cycles after the clock edge that samples start_i=1 in IDLE.
//    Same latency for special operands.
//  - a_i and rnd_i are captured at start. start_i is ignored outside IDLE.
//  - PREP: classify; unbias exponent (normalise subnormal when enabled).
//    If unbiased exp is odd, shift significand left 1 and use exp-1. Result exp = exp/2 + 127.
//  - ITER: restoring digit-by-digit root, 1 bit/cycle, 25 cycles.
//    Produces 1.23 root bits + guard bit. Sticky = (final remainder != 0).
//  - RND: result sign positive (except -0).
//    Round up if: RNE guard & (sticky | lsb); RMM guard; RUP guard|sticky; RTZ/RDN never.
//    Mantissa carry increments the exponent.
//  - Specials, no iteration data used:
//    - sNaN -> 0x7FC00000, NV.
//    - qNaN -> 0x7FC00000, no flags.
//    - Negative nonzero (incl. -inf) -> 0x7FC00000, NV.
//    - +-0 -> same zero, no flags.
//    - +inf -> +inf, no flags.
//  - Flags:
//    - NX = guard|sticky for finite nonzero results.
//    - DZ, OF, UF always 0 (root of binary32 never overflows or underflows).
//  - done_o registered; result_o/flags_o update in the same cycle done_o rises.
// CONFIGURATION
//  FP_SQRT_SUBNORM_EN defined:
//    - Subnormal inputs are normalised (leading-zero count) and rooted exactly like normals.
//  Undefined:
//    - Subnormal inputs flush to zero of the same sign.
//    - Result is that zero, flags 0, same 27-cycle latency.
// TESTING
//  - a=0x40800000 (4.0), rnd=RTZ -> result 0x40000000, flags 00000, done_o exactly 27 cycles after start.
//  - a=0x40000000 (2.0): RNE -> 0x3FB504F3 flags 00001; RTZ -> 0x3FB504F3 00001; RUP -> 0x3FB504F4 00001.
//  - a=0xC0800000 -> 0x7FC00000 flags 10000.
//    a=0x7F800000 -> 0x7F800000 flags 00000.
//    a=0x80000000 -> 0x80000000 flags 00000.
//    a=0x7F800001 -> 0x7FC00000 flags 10000.
//  - a=0x00000001, rnd=RNE: with FP_SQRT_SUBNORM_EN -> 0x1A3504F3 flags 00001; without -> 0x00000000 flags 00000.
//  - Start with a=0x40000000, drop reset_i at cycle 10 -> outputs 0, no done_o.
//    After release, start a=0x41100000 (9.0) -> 0x40400000 flags 00000.
//  - start_i held high continuously -> one result per 28 cycles; mid-operation starts ignored, no early done_o.

Source files
------------

// File: rtl/fp_sqrt_rnd.sv
// ---------------------------------------------------------------------------
// fp_sqrt_rnd
//   Iterative IEEE-754 binary32 square root with integrated rounding and
//   exception flags. This is the sqrt path of the FP execution unit and sits
//   beside the divider.
//
//   Operation: IDLE -> PREP -> ITER (25 cycles) -> RND -> IDLE.
//   done_o pulses exactly 27 cycles after the edge that accepts start_i, for
//   every operand class, including specials.
//
// Ports
//   clk_i     in   1   single clock, rising edge
//   reset_i   in   1   asynchronous, active-low reset
//   a_i       in   32  operand {sign, exp[7:0], man[22:0]}, captured at start
//   start_i   in   1   start request, sampled only in IDLE
//   rnd_i     in   3   RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4 (others act as RNE)
//   done_o    out  1   one-cycle pulse: result_o/flags_o just updated
//   result_o  out  32  rounded root, held until the next completed operation
//   flags_o   out  5   {NV,DZ,OF,UF,NX}, held with result_o
//
// Configuration
//   FP_SQRT_SUBNORM_EN  defined   : subnormal inputs are normalised with a
//                                   leading-zero count and rooted like normals.
//                       undefined : subnormal inputs flush to a zero of the
//                                   same sign (flags 0, same latency).
//
// Only EXP_W = 8 and MAN_W = 23 are supported.
// ---------------------------------------------------------------------------
module fp_sqrt_rnd #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] a_i,
    input  logic        start_i,
    input  logic [2:0]  rnd_i,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o
);

    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    // Root bits produced: 1 integer + MAN_W fraction + 1 guard.
    localparam int ITER_N = MAN_W + 2;
    // Radicand consumed two bits per iteration.
    localparam int RAD_W  = 2 * ITER_N;
    // Remainder never exceeds 2*root, so root width + 3 holds the shifted value.
    localparam int REM_W  = ITER_N + 3;

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);
    localparam logic signed [9:0] EMIN_S = 10'(1 - BIAS);
    localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]       POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_RND  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rnd_mode_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q;
    logic [2:0]         rnd_q;
    logic [RAD_W-1:0]   rad_q;
    logic [REM_W-1:0]   rem_q;
    logic [ITER_N-1:0]  root_q;
    logic [4:0]         cnt_q;
    logic [7:0]         exp_q;

`ifdef FP_SQRT_SUBNORM_EN
    // Leading zeros of a 24-bit significand; only ever called with bit 23 = 0
    // and a nonzero value, so the count lies in 1..23.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = '0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + 5'd1;
            end
        end
        return n;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Operand classification and radicand preparation (from the captured
    // operand, so the same decode serves PREP and RND).
    // -----------------------------------------------------------------------
    logic                a_sign;
    logic [7:0]          a_exp;
    logic [22:0]         a_man;
    logic                is_special;
    logic [31:0]         spc_res;
    logic                spc_nv;
    logic [23:0]         prep_sig;
    logic signed [9:0]   prep_e;
    logic signed [9:0]   prep_exp_s;
    logic [RAD_W-1:0]    prep_rad;
    logic [7:0]          prep_exp;
`ifdef FP_SQRT_SUBNORM_EN
    logic [4:0]          sub_lz;
`endif

    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        a_sign     = a_q[31];
        a_exp      = a_q[30:23];
        a_man      = a_q[22:0];
        is_special = 1'b0;
        spc_res    = QNAN;
        spc_nv     = 1'b0;
        prep_sig   = {1'b1, a_man};
        prep_e     = $signed({2'b00, a_exp}) - BIAS_S;
`ifdef FP_SQRT_SUBNORM_EN
        sub_lz     = '0;
`endif

        if (a_exp == 8'hFF) begin
            is_special = 1'b1;
            if (a_man != '0)  spc_nv  = ~a_man[22];   // signalling NaN
            else if (a_sign)  spc_nv  = 1'b1;         // -inf
            else              spc_res = POS_INF;
        end else if (a_exp == 8'h00 && a_man == '0) begin
            is_special = 1'b1;
            spc_res    = {a_sign, 31'b0};
        end else if (a_exp == 8'h00) begin
`ifdef FP_SQRT_SUBNORM_EN
            if (a_sign) begin
                is_special = 1'b1;
                spc_nv     = 1'b1;
            end else begin
                sub_lz   = lzc24({1'b0, a_man});
                prep_sig = {1'b0, a_man} << sub_lz;
                prep_e   = EMIN_S - $signed({5'b00000, sub_lz});
            end
`else
            is_special = 1'b1;
            spc_res    = {a_sign, 31'b0};
`endif
        end else if (a_sign) begin
            is_special = 1'b1;
            spc_nv     = 1'b1;
        end

        // Odd exponent: double the significand so the halved exponent is
        // exact. The radicand is scaled so its integer root carries 1.23 bits
        // plus a guard bit.
        prep_rad   = prep_e[0] ? {prep_sig, 26'b0} : {1'b0, prep_sig, 25'b0};
        // Arithmetic shift floors odd exponents, matching the doubled
        // significand.
        prep_exp_s = (prep_e >>> 1) + BIAS_S;
        prep_exp   = prep_exp_s[7:0];
    end

    // -----------------------------------------------------------------------
    // One restoring root step: bring down two radicand bits and try
    // subtracting (4*root + 1).
    // -----------------------------------------------------------------------
    logic [REM_W-1:0]  rem_sh;
    logic [REM_W-1:0]  trial;
    logic [REM_W-1:0]  rem_nx;
    logic [ITER_N-1:0] root_nx;

    always_comb begin
        rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
        trial  = {1'b0, root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = {root_q[ITER_N-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh;
            root_nx = {root_q[ITER_N-2:0], 1'b0};
        end
    end

    // -----------------------------------------------------------------------
    // Rounding. The root is always positive, so RDN behaves as RTZ and RUP
    // as round-away. A mantissa carry bumps the exponent; the mantissa field
    // is then all zero.
    // -----------------------------------------------------------------------
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] man_sum;
    logic [7:0]  rnd_exp;
    logic [31:0] rnd_res;

    always_comb begin
        guard  = root_q[0];
        sticky = |rem_q;
        case (rnd_q)
            RM_RTZ, RM_RDN: round_up = 1'b0;
            RM_RUP:         round_up = guard | sticky;
            RM_RMM:         round_up = guard;
            default:        round_up = guard & (sticky | root_q[1]);
        endcase
        man_sum = {1'b0, root_q[23:1]} + {23'b0, round_up};
        rnd_exp = exp_q + {7'b0, man_sum[23]};
        rnd_res = {1'b0, rnd_exp, man_sum[22:0]};
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_PREP;
            S_PREP: state_d = S_ITER;
            S_ITER: if (cnt_q == 5'(ITER_N - 1)) state_d = S_RND;
            S_RND:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            a_q      <= '0;
            rnd_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q   <= a_i;
                        rnd_q <= rnd_i;
                    end
                end
                S_PREP: begin
                    rad_q  <= prep_rad;
                    rem_q  <= '0;
                    root_q <= '0;
                    exp_q  <= prep_exp;
                    cnt_q  <= '0;
                end
                S_ITER: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    cnt_q  <= cnt_q + 5'd1;
                end
                S_RND: begin
                    done_o <= 1'b1;
                    if (is_special) begin
                        result_o <= spc_res;
                        flags_o  <= {spc_nv, 4'b0000};
                    end else begin
                        result_o <= rnd_res;
                        flags_o  <= {4'b0000, guard | sticky};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_rnd.sv
// ---------------------------------------------------------------------------
// tb_fp_sqrt_rnd
//   Directed self-checking bench for fp_sqrt_rnd. Expected results are pushed
//   to a scoreboard queue when an operation is started and popped when
//   done_o pulses. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fp_sqrt_rnd;

    localparam int LATENCY = 27;
    localparam int TIMEOUT = 40;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic        start;
    logic [2:0]  rnd;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    fp_sqrt_rnd dut (
        .clk_i    (clk),
        .reset_i  (rst_n),
        .a_i      (a),
        .start_i  (start),
        .rnd_i    (rnd),
        .done_o   (done),
        .result_o (result),
        .flags_o  (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
    endtask

    task automatic expect_result(input logic [31:0] r, input logic [4:0] f, input string tag);
        exp_t e;
        e.res = r;
        e.flg = f;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        check("sb_pending", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_res"}, result, e.res);
            check({e.tag, "_flags"}, {27'b0, flags}, {27'b0, e.flg});
        end
    endtask

    // Start one operation, scramble a_i/rnd_i after acceptance, then wait
    // (bounded) for done_o and check latency, result, flags and pulse width.
    task automatic run_op(input logic [31:0] op, input logic [2:0] mode,
                          input logic [31:0] r, input logic [4:0] f, input string tag);
        int cyc;
        expect_result(r, f, tag);
        @(negedge clk);
        a     = op;
        rnd   = mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        rnd   = 3'($urandom);
        cyc   = 0;
        while (done !== 1'b1 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
        if (done === 1'b1) pop_check();
        else               sb.delete();
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done;
        int first_k;
        int second_k;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        rnd   = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0000_0000);
        check("reset_flags", {27'b0, flags}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        // Exact roots and the rounding modes on an inexact root.
        run_op(32'h4080_0000, RTZ, 32'h4000_0000, 5'b00000, "sqrt4_rtz");
        run_op(32'h4000_0000, RNE, 32'h3FB5_04F3, 5'b00001, "sqrt2_rne");
        run_op(32'h4000_0000, RTZ, 32'h3FB5_04F3, 5'b00001, "sqrt2_rtz");
        run_op(32'h4000_0000, RUP, 32'h3FB5_04F4, 5'b00001, "sqrt2_rup");
        run_op(32'h4000_0000, RDN, 32'h3FB5_04F3, 5'b00001, "sqrt2_rdn");
        run_op(32'h4000_0000, RMM, 32'h3FB5_04F3, 5'b00001, "sqrt2_rmm");
        run_op(32'h4000_0000, 3'd7, 32'h3FB5_04F3, 5'b00001, "sqrt2_mode7");
        // sqrt(5): guard=1, sticky=1 -> round up for RNE/RMM, not for RTZ.
        run_op(32'h40A0_0000, RNE, 32'h400F_1BBD, 5'b00001, "sqrt5_rne");
        run_op(32'h40A0_0000, RTZ, 32'h400F_1BBC, 5'b00001, "sqrt5_rtz");
        run_op(32'h40A0_0000, RMM, 32'h400F_1BBD, 5'b00001, "sqrt5_rmm");
        // Negative unbiased exponents, even and odd.
        run_op(32'h3E80_0000, RNE, 32'h3F00_0000, 5'b00000, "sqrt_quarter");
        run_op(32'h3F00_0000, RNE, 32'h3F35_04F3, 5'b00001, "sqrt_half");
        // Largest normal: RUP carries out of the mantissa into the exponent.
        run_op(32'h7F7F_FFFF, RNE, 32'h5F7F_FFFF, 5'b00001, "max_rne");
        run_op(32'h7F7F_FFFF, RUP, 32'h5F80_0000, 5'b00001, "max_rup_carry");

        // Special operands.
        run_op(32'hC080_0000, RNE, 32'h7FC0_0000, 5'b10000, "neg4");
        run_op(32'h7F80_0000, RNE, 32'h7F80_0000, 5'b00000, "pos_inf");
        run_op(32'hFF80_0000, RNE, 32'h7FC0_0000, 5'b10000, "neg_inf");
        run_op(32'h8000_0000, RNE, 32'h8000_0000, 5'b00000, "neg_zero");
        run_op(32'h0000_0000, RUP, 32'h0000_0000, 5'b00000, "pos_zero");
        run_op(32'h7F80_0001, RNE, 32'h7FC0_0000, 5'b10000, "snan");
        run_op(32'h7FC0_0001, RNE, 32'h7FC0_0000, 5'b00000, "qnan");

        // Subnormal operands.
`ifdef FP_SQRT_SUBNORM_EN
        run_op(32'h0000_0001, RNE, 32'h1A35_04F3, 5'b00001, "subnorm_min");
        run_op(32'h8000_0001, RNE, 32'h7FC0_0000, 5'b10000, "subnorm_neg");
`else
        run_op(32'h0000_0001, RNE, 32'h0000_0000, 5'b00000, "subnorm_min");
        run_op(32'h8000_0001, RNE, 32'h8000_0000, 5'b00000, "subnorm_neg");
`endif

        // Leave a nonzero held result so the abort-reset clear is visible.
        run_op(32'h4000_0000, RNE, 32'h3FB5_04F3, 5'b00001, "pre_abort");

        // Abort an operation with reset at cycle 10.
        n_done = 0;
        @(negedge clk);
        a     = 32'h4000_0000;
        rnd   = RNE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 32'h0000_0000);
        check("abort_flags", {27'b0, flags}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 35; k++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op(32'h4110_0000, RNE, 32'h4040_0000, 5'b00000, "sqrt9_after_abort");

        // start held high: one result per 28 cycles, operand captured only
        // when the block is idle.
        expect_result(32'h4000_0000, 5'b00000, "held_first");
        expect_result(32'h4040_0000, 5'b00000, "held_second");
        n_done   = 0;
        first_k  = -1;
        second_k = -1;
        @(negedge clk);
        a     = 32'h4080_0000;
        rnd   = RTZ;
        start = 1'b1;
        @(negedge clk);
        a = 32'h4110_0000;
        for (int k = 0; k <= 62; k++) begin
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1)      first_k  = k;
                else if (n_done == 2) second_k = k;
                pop_check();
            end
            if (k == 55) start = 1'b0;
            @(negedge clk);
        end
        check("held_done_count", 32'(n_done), 32'd2);
        check("held_first_cycle", 32'(first_k), 32'(LATENCY));
        check("held_second_cycle", 32'(second_k), 32'(2 * LATENCY + 1));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
